// File: rtl/uart_arb_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
// Holds the FSM state encoding and a small modulo-increment helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int ARB_N_REQ       = 4;
    localparam int ARB_DATA_W      = 8;
    localparam int ARB_TIMEOUT_CYC = 16;

    // Next index after idx, wrapping at n (n need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr
// upward with wrap-around. Kept generic so other bus arbiters can reuse it.
import uart_arb_pkg::*;

module rr_pick #(
    parameter int N_REQ = ARB_N_REQ,
    parameter int IW    = $clog2(ARB_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    logic [IW-1:0] idx_s;

    // Scan N_REQ positions starting at ptr; the first asserted request wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx_s  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = IW'((32'(ptr) + 32'(k)) % 32'(N_REQ));
            if (!valid && req[idx_s]) begin
                valid  = 1'b1;
                winner = idx_s;
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte
// sources. Captures one byte per grant, strobes tx_start for one cycle and
// follows tx_busy through its rise and fall before serving the next source.
// Optional feature: define ARB_TIMEOUT_EN to abandon a start that the
// transmitter never acknowledges within TIMEOUT_CYC cycles.
import uart_arb_pkg::*;

module uart_tx_arbiter #(
    parameter int N_REQ       = ARB_N_REQ,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      err_timeout
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t          state_r, state_nxt_s;
    logic [IW-1:0]       ptr_r, ptr_nxt_s;
    logic [IW-1:0]       owner_r, owner_nxt_s;
    logic [N_REQ-1:0]    gnt_r, gnt_nxt_s;
    logic                tx_start_r, tx_start_nxt_s;
    logic [DATA_W-1:0]   tx_data_r, tx_data_nxt_s;
    logic                valid_s;
    logic [IW-1:0]       winner_s;
    logic                timeout_s;
    logic [IW-1:0]       ptr_after_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .valid  (valid_s),
        .winner (winner_s)
    );

    assign ptr_after_s = IW'(wrap_inc(32'(owner_r), 32'(N_REQ)));

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt_r;
    logic          err_r;

    assign timeout_s   = (tmo_cnt_r == CW'(TIMEOUT_CYC - 1));
    assign err_timeout = err_r;

    // Count cycles spent in WAIT_BUSY (zero elsewhere) and flag an unacknowledged start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
            err_r     <= 1'b0;
        end else begin
            tmo_cnt_r <= (state_r == WAIT_BUSY) ? tmo_cnt_r + CW'(1) : '0;
            err_r     <= (state_r == WAIT_BUSY) && !tx_busy && timeout_s;
        end
    end
`else
    assign timeout_s   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state, capture and pointer decisions; strobes default low every cycle.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        owner_nxt_s    = owner_r;
        gnt_nxt_s      = '0;
        tx_start_nxt_s = 1'b0;
        tx_data_nxt_s  = tx_data_r;
        case (state_r)
            IDLE: begin
                if (valid_s && !tx_busy) begin
                    gnt_nxt_s[winner_s] = 1'b1;
                    tx_start_nxt_s      = 1'b1;
                    tx_data_nxt_s       = req_data[32'(winner_s)*DATA_W +: DATA_W];
                    owner_nxt_s         = winner_s;
                    state_nxt_s         = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                state_nxt_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (timeout_s) begin
                    // Skip past a stuck transmitter so others are not starved.
                    ptr_nxt_s   = ptr_after_s;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    ptr_nxt_s   = ptr_after_s;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs; reset drops any captured byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            owner_r    <= '0;
            gnt_r      <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            owner_r    <= owner_nxt_s;
            gnt_r      <= gnt_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
        end
    end

    assign gnt      = gnt_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign owner    = owner_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8).
// A small transmitter model raises tx_busy the cycle after tx_start and
// holds it for 10 cycles; tests can switch to a manually driven tx_busy.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0000_0000;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  owner;
    logic        err_timeout;

    logic        auto_busy = 1'b1;
    logic        man_busy = 1'b0;
    logic        model_busy;
    int          model_cnt;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .owner       (owner),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    assign tx_busy = auto_busy ? model_busy : man_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (tx_start) begin
            model_busy <= 1'b1;
            model_cnt  <= 9;
        end else if (model_cnt != 0) begin
            model_cnt  <= model_cnt - 1;
        end else begin
            model_busy <= 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        man_busy = 1'b0;
        auto_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (gnt == 4'b0000 && cyc < maxc);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int starts;
        apply_reset();
        req_data = 32'h0000_0041;
        req = 4'b0001;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL single_start: got %b expected 1", tx_start); end
        vectors++; if (tx_data !== 8'h41) begin miscompares++; $display("FAIL single_data: got %h expected 41", tx_data); end
        req = 4'b0000;
        starts = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (tx_start || gnt != 4'b0000) starts++;
        end
        vectors++; if (starts !== 0) begin miscompares++; $display("FAIL single_extra_start: got %0d expected 0", starts); end
        vectors++; if (tx_data !== 8'h41) begin miscompares++; $display("FAIL single_data_hold: got %h expected 41", tx_data); end
    endtask

    task automatic test_contention();
        int cyc;
        logic [3:0] eg;
        apply_reset();
        req_data = 32'h1312_1110;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_gnt(20, cyc);
            eg = 4'b0001 << (t % 4);
            vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL contention_gnt[%0d]: got %b expected %b", t, gnt, eg); end
            vectors++; if (tx_data !== 8'h10 + 8'(t % 4)) begin miscompares++; $display("FAIL contention_data[%0d]: got %h expected %h", t, tx_data, 8'h10 + 8'(t % 4)); end
            vectors++; if (owner !== 2'(t % 4)) begin miscompares++; $display("FAIL contention_owner[%0d]: got %0d expected %0d", t, owner, t % 4); end
            vectors++; if (cyc !== ((t == 0) ? 1 : 13)) begin miscompares++; $display("FAIL contention_spacing[%0d]: got %0d expected %0d", t, cyc, (t == 0) ? 1 : 13); end
        end
        req = 4'b0000;
    endtask

    task automatic test_rotation();
        int cyc;
        apply_reset();
        req_data = 32'hDDCC_BBAA;
        req = 4'b0010;
        wait_gnt(5, cyc);
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rot_first_gnt: got %b expected 0010", gnt); end
        req = 4'b0000;
        repeat (13) @(negedge clk);
        req = 4'b0011;
        wait_gnt(5, cyc);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL rot_wrap_gnt: got %b expected 0001", gnt); end
        vectors++; if (tx_data !== 8'hAA) begin miscompares++; $display("FAIL rot_wrap_data: got %h expected aa", tx_data); end
        req = 4'b0010;
        wait_gnt(20, cyc);
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rot_next_gnt: got %b expected 0010", gnt); end
        req = 4'b0000;
    endtask

    task automatic test_busy_gate();
        int starts;
        int grants;
        apply_reset();
        auto_busy = 1'b0;
        man_busy = 1'b1;
        req_data = 32'h0077_0000;
        req = 4'b0100;
        starts = 0;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
            if (gnt != 4'b0000) grants++;
        end
        vectors++; if (starts !== 0) begin miscompares++; $display("FAIL gate_start_while_busy: got %0d expected 0", starts); end
        vectors++; if (grants !== 0) begin miscompares++; $display("FAIL gate_gnt_while_busy: got %0d expected 0", grants); end
        req = 4'b0000;
        @(negedge clk);
        man_busy = 1'b0;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != 4'b0000 || tx_start) grants++;
        end
        vectors++; if (grants !== 0) begin miscompares++; $display("FAIL gate_withdrawn: got %0d expected 0", grants); end
        req = 4'b0100;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL gate_release_gnt: got %b expected 0100", gnt); end
        vectors++; if (tx_data !== 8'h77) begin miscompares++; $display("FAIL gate_release_data: got %h expected 77", tx_data); end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        int err_first;
        int err_count;
        int gnt_first;
        logic [3:0] gnt_seen;
        apply_reset();
        auto_busy = 1'b0;
        man_busy = 1'b0;
        req_data = 32'h0000_2211;
        req = 4'b0011;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL tmo_first_gnt: got %b expected 0001", gnt); end
        req = 4'b0010;
        err_first = -1;
        err_count = 0;
        gnt_first = -1;
        gnt_seen = 4'b0000;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (err_timeout) begin
                err_count++;
                if (err_first < 0) err_first = c;
            end
            if (gnt != 4'b0000 && gnt_first < 0) begin
                gnt_first = c;
                gnt_seen = gnt;
                req = 4'b0000;
            end
        end
`ifdef ARB_TIMEOUT_EN
        vectors++; if (err_first !== 17) begin miscompares++; $display("FAIL tmo_err_cycle: got %0d expected 17", err_first); end
        vectors++; if (err_count !== 1) begin miscompares++; $display("FAIL tmo_err_width: got %0d expected 1", err_count); end
        vectors++; if (gnt_first !== 18) begin miscompares++; $display("FAIL tmo_next_cycle: got %0d expected 18", gnt_first); end
        vectors++; if (gnt_seen !== 4'b0010) begin miscompares++; $display("FAIL tmo_next_gnt: got %b expected 0010", gnt_seen); end
`else
        vectors++; if (err_count !== 0) begin miscompares++; $display("FAIL tmo_err_absent: got %0d expected 0", err_count); end
        vectors++; if (gnt_first !== -1) begin miscompares++; $display("FAIL tmo_stuck_wait: got %0d expected -1", gnt_first); end
        man_busy = 1'b1;
        @(negedge clk);
        man_busy = 1'b0;
        wait_gnt(5, gnt_first);
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL tmo_resume_gnt: got %b expected 0010", gnt); end
        vectors++; if (gnt_first !== 2) begin miscompares++; $display("FAIL tmo_resume_cycle: got %0d expected 2", gnt_first); end
        req = 4'b0000;
`endif
    endtask

    task automatic test_reset_mid();
        int cyc;
        apply_reset();
        req_data = 32'h00C3_005A;
        req = 4'b0001;
        wait_gnt(5, cyc);
        req = 4'b0000;
        repeat (13) @(negedge clk);
        req = 4'b0100;
        wait_gnt(5, cyc);
        vectors++; if (owner !== 2'd2) begin miscompares++; $display("FAIL mid_owner_before: got %0d expected 2", owner); end
        vectors++; if (tx_data !== 8'hC3) begin miscompares++; $display("FAIL mid_data_before: got %h expected c3", tx_data); end
        req = 4'b0000;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if (gnt !== 4'b0000 || tx_start !== 1'b0 || err_timeout !== 1'b0) begin miscompares++; $display("FAIL mid_async_strobes: got %b/%b/%b expected 0000/0/0", gnt, tx_start, err_timeout); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL mid_async_data: got %h expected 00", tx_data); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL mid_async_owner: got %0d expected 0", owner); end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL mid_ptr_cleared: got %b expected 0001", gnt); end
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL mid_release_first: got %b expected 0000", gnt); end
        @(negedge clk);
        vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL mid_release_gnt: got %b expected 1000", gnt); end
        vectors++; if (owner !== 2'd3) begin miscompares++; $display("FAIL mid_release_owner: got %0d expected 3", owner); end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_busy_gate();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that lets up to N_REQ byte sources share the design's single UART transmitter. It sits between the requesters (echo path, status reporter, debug dump) and the `uart_tx` start/data/busy interface. It captures one byte per grant, issues a one-cycle start strobe, and tracks the transmitter's busy window before it serves the next requester.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: byte width; must match `uart_tx` data.
- TIMEOUT_CYC, 16: cycles allowed for tx_busy to rise after tx_start. Used only with ARB_TIMEOUT_EN.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester request; held high with data stable until its gnt.
- req_data  in  N_REQ*DATA_W  packed bytes; requester i on bits [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot, one-cycle pulse; the byte was captured.
- tx_data  out  DATA_W  byte to `uart_tx`; held until the next capture.
- tx_start  out  1  one-cycle start strobe to `uart_tx`.
- tx_busy  in  1  `uart_tx` busy.
- owner  out  $clog2(N_REQ)  index of the last granted requester.
- err_timeout  out  1  one-cycle pulse when a start was not acknowledged.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: if req != 0 and tx_busy == 0, pick the winner by round-robin from pointer ptr. The winner is the first set req[i] scanning i = ptr, ptr+1, … mod N_REQ. At the clock edge:
  - capture tx_data <= req_data[winner]
  - set gnt[winner] <= 1, tx_start <= 1, owner <= winner
  - go to START.
- In IDLE with tx_busy == 1, nothing is issued.
- START: gnt and tx_start are high for exactly this cycle. At the edge, clear both and go to WAIT_BUSY.
- WAIT_BUSY: when tx_busy == 1, go to WAIT_DONE.
- WAIT_DONE: when tx_busy == 0, set ptr <= owner+1 mod N_REQ and go to IDLE.
- ptr advances only on a completed transfer. A timed-out transfer also advances it, so a stuck transmitter cannot starve other requesters.
- req withdrawn before its gnt: allowed. Nothing is captured and the withdrawn request is not remembered.
- req still high after gnt: treated as a new byte request. It is eligible at the next IDLE, subject to rotation.
- Simultaneous requests: exactly one gnt per transfer. With all requesters busy, service order is 0,1,2,3,0,…
- Reset mid-operation: all outputs return to their reset values immediately, the state goes to IDLE, and any captured byte is dropped. The `uart_tx` instance is reset by the same rst.

## Timing
- Reset values:
  - gnt = 0, tx_start = 0, tx_data = 0, owner = 0, err_timeout = 0
  - state = IDLE, ptr = 0 (requester 0 has first priority).
- Latency: req sampled high in IDLE on cycle n → gnt and tx_start high on cycle n+1.
- tx_start is never high on two consecutive cycles. It is never asserted while tx_busy == 1 is sampled in IDLE.
- Back-to-back transfers: tx_busy falling is sampled at edge k. The arbiter is in IDLE at cycle k+1, and the next tx_start is at cycle k+2.
- tx_busy already high in the START cycle: WAIT_BUSY exits on the first sampled high.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT_BUSY. After TIMEOUT_CYC cycles without tx_busy, pulse err_timeout for 1 cycle, advance ptr, and go to IDLE.
  - The counter clears on entry to WAIT_BUSY.
- ARB_TIMEOUT_EN undefined:
  - WAIT_BUSY waits indefinitely.
  - err_timeout is tied to 0 and no counter logic is synthesized.
  - The port remains present in both builds.

## Structure
- Package uart_arb_pkg:
  - state enum arb_state_t {IDLE, START, WAIT_BUSY, WAIT_DONE}
  - default constants ARB_N_REQ = 4, ARB_DATA_W = 8, ARB_TIMEOUT_CYC = 16.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: valid, winner index.
  - Reusable by future bus arbiters.
- The top-level module holds the FSM, capture registers, pointer and optional timeout counter.

## Test plan
- Single request: req = 4'b0001, req_data[7:0] = 8'h41, tx_busy model rises 1 cycle after start and falls 10 cycles later.
  - Expect gnt = 0001 and tx_start on cycle n+1, tx_data = 8'h41, then IDLE.
- Contention: req = 4'b1111 held, data = 8'h10/11/12/13.
  - Expect tx_data sequence 10, 11, 12, 13, 10.
  - Expect exactly one gnt per transfer and owner 0, 1, 2, 3, 0.
- Rotation with gaps: ptr = 2 after serving requester 1, then req = 4'b0011.
  - Expect requester 0 granted, not 1.
- Withdrawal and busy gating:
  - tx_busy held 1 in IDLE with req = 4'b0100: expect no tx_start.
  - Drop req before busy clears: expect no gnt ever.
- Timeout (ARB_TIMEOUT_EN): tx_busy stuck 0 after start.
  - Expect err_timeout pulse 16 cycles after entering WAIT_BUSY, return to IDLE, and the next requester served.
  - In the build without the macro, expect the arbiter to remain in WAIT_BUSY.
- Reset mid-transfer: assert rst during WAIT_DONE.
  - Expect all outputs 0 asynchronously and ptr = 0.
  - After release with req = 4'b1000, expect gnt = 1000 on the second cycle.
